led_pattern_gen: RTL and testbench

- Parametrised multi-LED pattern generator with a runtime-selectable pattern mode.
- Successor to the fixed two-LED running light: arbitrary LED count, step period and modes, plus pause and a step strobe.
- Sits at board top level, driven directly by the 27 MHz board clock. LED outputs go straight to pins.

---
 rtl/led_pkg.sv | 17 +
 rtl/step_timer.sv | 33 +++
 rtl/led_pattern_gen.sv | 107 ++++++++++
 tb/tb_led_pattern_gen.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - mode/direction constants and reset-pattern helper for led_pattern_gen
package led_pkg;

   localparam logic [1:0] MODE_ROT_L    = 2'b00;
   localparam logic [1:0] MODE_ROT_R    = 2'b01;
   localparam logic [1:0] MODE_PINGPONG = 2'b10;
   localparam logic [1:0] MODE_BLINK    = 2'b11;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Widest legal pattern; callers truncate to their LED count.
   function automatic logic [31:0] reset_pattern(input logic [1:0] m);
      return (m == MODE_BLINK) ? 32'hFFFF_FFFF : 32'd1;
   endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - step prescaler: counts 0..STEP_CYCLES-1, tick on the last count unless held
module step_timer #(
   parameter int STEP_CYCLES = 13_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic hold,
   output logic tick
);

   localparam int CNT_W = $clog2(STEP_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (!hold) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   assign tick = (cnt_q == LAST) && !hold;

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-LED pattern generator (rotate/ping-pong/blink); optional PWM dimming under LED_PWM_EN
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int LED_NUM     = 4,
   parameter int STEP_CYCLES = 13_500_000
`ifdef LED_PWM_EN
   ,
   parameter int PWM_DUTY    = 128
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   input  logic               pause,
   output logic [LED_NUM-1:0] led,
   output logic               step_pulse
);

   logic [1:0]         mode_q;
   logic [LED_NUM-1:0] pattern_q, pattern_d;
   logic               dir_q, dir_d;
   logic               step_pulse_q, step_pulse_d;
   logic               reload;
   logic               tick;

   // A mode change restarts the step and the pattern; this also keeps modes 00/01/10 one-hot.
   assign reload = (mode != mode_q);

   step_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_step_timer (
      .clk (clk),
      .rst (rst),
      .clr (reload),
      .hold(pause),
      .tick(tick)
   );

   always_comb begin
      pattern_d    = pattern_q;
      dir_d        = dir_q;
      step_pulse_d = 1'b0;
      if (reload) begin
         pattern_d = LED_NUM'(reset_pattern(mode));
         dir_d     = DIR_UP;
      end else if (tick) begin
         step_pulse_d = 1'b1;
         case (mode_q)
            MODE_ROT_L: pattern_d = (pattern_q << 1) | (pattern_q >> (LED_NUM - 1));
            MODE_ROT_R: pattern_d = (pattern_q >> 1) | (pattern_q << (LED_NUM - 1));
            MODE_PINGPONG: begin
               if (LED_NUM == 1) begin
                  pattern_d = pattern_q;
               end else if (dir_q == DIR_UP) begin
                  pattern_d = pattern_q << 1;
                  if (pattern_d[LED_NUM-1]) dir_d = DIR_DN;
               end else begin
                  pattern_d = pattern_q >> 1;
                  if (pattern_d[0]) dir_d = DIR_UP;
               end
            end
            default: pattern_d = ~pattern_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q       <= mode;
         pattern_q    <= LED_NUM'(reset_pattern(mode));
         dir_q        <= DIR_UP;
         step_pulse_q <= 1'b0;
      end else begin
         mode_q       <= mode;
         pattern_q    <= pattern_d;
         dir_q        <= dir_d;
         step_pulse_q <= step_pulse_d;
      end
   end

   assign step_pulse = step_pulse_q;

`ifdef LED_PWM_EN
   logic [7:0]         pwm_cnt_q;
   logic [LED_NUM-1:0] led_q;
   logic               pwm_on;

   // Widened compare so duties of 256 and above give full brightness.
   assign pwm_on = ({24'd0, pwm_cnt_q} < 32'(PWM_DUTY));

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q <= 8'd0;
         led_q     <= LED_NUM'(reset_pattern(mode)) & {LED_NUM{pwm_on}};
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 8'd1;
         led_q     <= pattern_d & {LED_NUM{pwm_on}};
      end
   end

   assign led = led_q;
`else
   assign led = pattern_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard bench for led_pattern_gen over three LED_NUM/STEP_CYCLES sizes
module tb_led_pattern_gen;

   typedef struct packed {
      logic [2:0][31:0] led;
      logic [2:0]       pulse;
   } exp_t;

   localparam int NL [3] = '{4, 1, 5};
   localparam int SC [3] = '{4, 2, 3};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pause = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] led0;
   logic [0:0] led1;
   logic [4:0] led2;
   logic       sp0, sp1, sp2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   exp_t expq [$];

   int m_modeq [3];
   int m_el    [3];
   int m_k     [3];

   always #5 clk = ~clk;

   led_pattern_gen #(.LED_NUM(4), .STEP_CYCLES(4)) u0 (
      .clk(clk), .rst(rst), .mode(mode), .pause(pause), .led(led0), .step_pulse(sp0));
   led_pattern_gen #(.LED_NUM(1), .STEP_CYCLES(2)) u1 (
      .clk(clk), .rst(rst), .mode(mode), .pause(pause), .led(led1), .step_pulse(sp1));
   led_pattern_gen #(.LED_NUM(5), .STEP_CYCLES(3)) u2 (
      .clk(clk), .rst(rst), .mode(mode), .pause(pause), .led(led2), .step_pulse(sp2));

   // Pattern after k steps in a mode, from the visible position of the lit LED.
   function automatic logic [31:0] pat(input int md, input int k, input int n);
      int p, r, pos;
      case (md)
         0: return 32'd1 << (k % n);
         1: return 32'd1 << ((n - (k % n)) % n);
         2: begin
            if (n == 1) return 32'd1;
            p   = 2 * (n - 1);
            r   = k % p;
            pos = (r < n) ? r : p - r;
            return 32'd1 << pos;
         end
         default: begin
            if (k % 2 != 0) return 32'd0;
            return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
         end
      endcase
   endfunction

   task automatic cycle(input logic r, input logic [1:0] md, input logic p);
      exp_t e;
      @(negedge clk);
      rst   = r;
      mode  = md;
      pause = p;
      for (int i = 0; i < 3; i++) begin
         e.pulse[i] = 1'b0;
         if (r || (int'(md) != m_modeq[i])) begin
            m_el[i] = 0;
            m_k[i]  = 0;
         end else if (!p) begin
            if (m_el[i] == SC[i] - 1) begin
               m_el[i]    = 0;
               m_k[i]     = m_k[i] + 1;
               e.pulse[i] = 1'b1;
            end else begin
               m_el[i] = m_el[i] + 1;
            end
         end
         m_modeq[i] = int'(md);
         e.led[i]   = pat(m_modeq[i], m_k[i], NL[i]);
      end
      expq.push_back(e);
   endtask

   task automatic run(input int n, input logic [1:0] md, input logic p);
      for (int i = 0; i < n; i++) cycle(1'b0, md, p);
   endtask

   initial begin : monitor
      exp_t e;
      logic [2:0][31:0] g;
      logic [2:0]       gp;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            cyc++;
            g  = {{27'd0, led2}, {31'd0, led1}, {28'd0, led0}};
            gp = {sp2, sp1, sp0};
            for (int i = 0; i < 3; i++) begin
               total++;
               if (g[i] !== e.led[i]) begin
                  bad++;
                  $display("FAIL led u%0d cyc=%0d got=%b want=%b", i, cyc, g[i], e.led[i]);
               end
               total++;
               if (gp[i] !== e.pulse[i]) begin
                  bad++;
                  $display("FAIL step_pulse u%0d cyc=%0d got=%b want=%b", i, cyc, gp[i], e.pulse[i]);
               end
            end
         end
      end
   end

   initial begin : stim
      logic [1:0] md;
      logic       p;
      cycle(1'b1, 2'b00, 1'b0);
      cycle(1'b1, 2'b00, 1'b0);
      run(20, 2'b00, 1'b0);
      cycle(1'b1, 2'b10, 1'b0);
      run(30, 2'b10, 1'b0);
      cycle(1'b1, 2'b11, 1'b0);
      run(10, 2'b11, 1'b0);
      run(14, 2'b01, 1'b0);
      cycle(1'b1, 2'b00, 1'b0);
      run(2, 2'b00, 1'b0);
      run(10, 2'b00, 1'b1);
      run(8, 2'b00, 1'b0);
      cycle(1'b1, 2'b00, 1'b0);
      run(9, 2'b00, 1'b0);
      cycle(1'b1, 2'b00, 1'b0);
      run(6, 2'b00, 1'b0);
      run(3, 2'b10, 1'b1);
      md = 2'b00;
      p  = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 24) == 0) md = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0)  p  = ~p;
         cycle(($urandom_range(0, 149) == 0), md, p);
      end
      for (int i = 0; i < 10 && expq.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (expq.size() > 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
